// File: rtl/query_patch_loader.sv
// -----------------------------------------------------------------------------
// query_patch_loader
//
// Purpose:
//   Drains the show-ahead input FIFO and packs each group of PATCH_SIZE
//   consecutive words into one query patch. Each patch is written to port 0
//   of the query-patch SRAM. After NUM_QUERYS patches have been written the
//   block raises `done` and holds it until the next `start`.
//
// Optional feature (compile-time macro):
//   QP_LOADER_CHECKSUM_EN - when defined, `checksum` is a running XOR of every
//                           dequeued word. When undefined, `checksum` is tied
//                           to 0 and no checksum register is built.
//
// Ports:
//   clk            in   single clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse that begins a load (ignored while busy)
//   fifo_rdata     in   FIFO head word (show-ahead)
//   fifo_rempty_n  in   FIFO holds at least one word
//   fifo_deq       out  pop the FIFO head at this clock edge
//   qp_mem_csb0    out  SRAM chip select, active-low
//   qp_mem_web0    out  SRAM write enable, active-low
//   qp_mem_addr0   out  patch address
//   qp_mem_wpatch0 out  patch write data (word 0 in the LSBs)
//   busy           out  load in progress (LOAD or WRITE)
//   done           out  all NUM_QUERYS patches written
//   checksum       out  running XOR of dequeued words (or 0)
// -----------------------------------------------------------------------------
module query_patch_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_QUERYS = 494,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_WIDTH-1:0]            fifo_rdata,
    input  logic                             fifo_rempty_n,
    output logic                             fifo_deq,
    output logic                             qp_mem_csb0,
    output logic                             qp_mem_web0,
    output logic [ADDR_WIDTH-1:0]            qp_mem_addr0,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] qp_mem_wpatch0,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH-1:0]            checksum
);

    localparam int PW  = DATA_WIDTH * PATCH_SIZE;
    localparam int WCW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
    localparam logic [WCW-1:0]        LAST_WORD  = WCW'(PATCH_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PATCH = ADDR_WIDTH'(NUM_QUERYS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [WCW-1:0]          word_cnt_q;
    logic [ADDR_WIDTH-1:0]   patch_cnt_q;
    logic [PW-1:0]           patch_q;
    logic [PW-1:0]           patch_d;
    logic                    csb_q;
    logic                    web_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [PW-1:0]           wpatch_q;
    logic                    done_q;
    logic                    start_ok;

    // Dequeue straight from the registered state so a continuously
    // non-empty FIFO is drained with no bubble between words.
    assign fifo_deq = (state_q == S_LOAD) && fifo_rempty_n;
    assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign start_ok = start && !busy;

    assign qp_mem_csb0    = csb_q;
    assign qp_mem_web0    = web_q;
    assign qp_mem_addr0   = addr_q;
    assign qp_mem_wpatch0 = wpatch_q;
    assign done           = done_q;

    // Patch register with the current head word merged into lane word_cnt.
    // Used both to update the patch and to capture the completed patch into
    // the write-data register on the last word, so WRITE can follow directly.
    always_comb begin
        patch_d = patch_q;
        for (int i = 0; i < PATCH_SIZE; i++) begin
            if (word_cnt_q == WCW'(i)) begin
                patch_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            patch_cnt_q <= '0;
            patch_q     <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr_q      <= '0;
            wpatch_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            // SRAM strobes are asserted only for the single WRITE cycle.
            csb_q <= 1'b1;
            web_q <= 1'b1;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        word_cnt_q  <= '0;
                        patch_cnt_q <= '0;
                        done_q      <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (fifo_rempty_n) begin
                        patch_q <= patch_d;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_q <= '0;
                            state_q    <= S_WRITE;
                            csb_q      <= 1'b0;
                            web_q      <= 1'b0;
                            addr_q     <= patch_cnt_q;
                            wpatch_q   <= patch_d;
                        end else begin
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (patch_cnt_q == LAST_PATCH) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        patch_cnt_q <= patch_cnt_q + ADDR_WIDTH'(1);
                        state_q     <= S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef QP_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (fifo_deq) begin
            checksum_q <= checksum_q ^ fifo_rdata;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_query_patch_loader.sv
module tb_query_patch_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] fifo_rdata;
    logic        fifo_rempty_n;
    logic        fifo_deq;
    logic        qp_mem_csb0;
    logic        qp_mem_web0;
    logic [8:0]  qp_mem_addr0;
    logic [54:0] qp_mem_wpatch0;
    logic        busy;
    logic        done;
    logic [10:0] checksum;

    always #5 clk = ~clk;

    query_patch_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .fifo_rdata     (fifo_rdata),
        .fifo_rempty_n  (fifo_rempty_n),
        .fifo_deq       (fifo_deq),
        .qp_mem_csb0    (qp_mem_csb0),
        .qp_mem_web0    (qp_mem_web0),
        .qp_mem_addr0   (qp_mem_addr0),
        .qp_mem_wpatch0 (qp_mem_wpatch0),
        .busy           (busy),
        .done           (done),
        .checksum       (checksum)
    );

    // Show-ahead FIFO model: the main process appends at wr_ptr, the DUT pops.
    logic [10:0] mem [0:16383];
    int rd_ptr = 0;
    int wr_ptr = 0;

    assign fifo_rempty_n = (rd_ptr != wr_ptr);
    assign fifo_rdata    = mem[rd_ptr[13:0]];

    always @(posedge clk) begin
        if (fifo_deq) rd_ptr <= rd_ptr + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected SRAM writes.
    typedef struct packed {
        logic [8:0]  addr;
        logic [54:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int          acc_cnt;
    int          acc_addr;
    logic [54:0] acc_patch;
    logic [10:0] exp_ck;

    task automatic begin_load();
        acc_cnt   = 0;
        acc_addr  = 0;
        acc_patch = '0;
        exp_ck    = '0;
    endtask

    task automatic push_word(input logic [10:0] w);
        exp_t e;
        mem[wr_ptr[13:0]] = w;
        wr_ptr++;
        exp_ck = exp_ck ^ w;
        acc_patch[acc_cnt*11 +: 11] = w;
        acc_cnt++;
        if (acc_cnt == 5) begin
            e.addr = 9'(acc_addr);
            e.data = acc_patch;
            exp_q.push_back(e);
            acc_addr++;
            acc_cnt = 0;
        end
    endtask

    // Monitor: every SRAM write is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !qp_mem_csb0) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                         qp_mem_addr0, qp_mem_wpatch0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 64'(qp_mem_addr0), 64'(mon_e.addr));
                chk("write_data", 64'(qp_mem_wpatch0), 64'(mon_e.data));
                chk("write_web0", 64'(qp_mem_web0), 64'd0);
                $display("[TB] write addr %0d data 0x%014h", qp_mem_addr0, qp_mem_wpatch0);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_fifo_deq"}, 64'(fifo_deq), 64'd0);
        chk({tag, "_csb0"},     64'(qp_mem_csb0), 64'd1);
        chk({tag, "_web0"},     64'(qp_mem_web0), 64'd1);
        chk({tag, "_addr0"},    64'(qp_mem_addr0), 64'd0);
        chk({tag, "_wpatch0"},  64'(qp_mem_wpatch0), 64'd0);
        chk({tag, "_busy"},     64'(busy), 64'd0);
        chk({tag, "_done"},     64'(done), 64'd0);
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [10:0] ck_expect;

    task automatic chk_checksum(input string name);
`ifdef QP_LOADER_CHECKSUM_EN
        ck_expect = exp_ck;
`else
        ck_expect = '0;
`endif
        chk(name, 64'(checksum), 64'(ck_expect));
    endtask

    // Run until done, counting clock edges since the start edge.
    // With pulses set, start is pulsed in a LOAD cycle and in a WRITE cycle.
    task automatic run_to_done(input bit pulses, output int cyc);
        logic [54:0] p0_exp;
        bit          pw;
        bit          last_seen;
        p0_exp    = {11'd4, 11'd3, 11'd2, 11'd1, 11'd0};
        pw        = 1'b0;
        last_seen = 1'b0;
        cyc       = 0;
        while (cyc < 4000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (pulses) begin
                if (cyc == 3) start = 1'b1;
                if (cyc == 4) chk("busy_after_load_pulse", 64'(busy), 64'd1);
                if (!qp_mem_csb0 && qp_mem_addr0 == 9'd5 && !pw) begin
                    start = 1'b1;
                    pw    = 1'b1;
                end
                if (!qp_mem_csb0 && qp_mem_addr0 == 9'd0)
                    chk("patch0_hand", 64'(qp_mem_wpatch0), 64'(p0_exp));
                if (!qp_mem_csb0 && qp_mem_addr0 == 9'd493) last_seen = 1'b1;
            end
        end
        start = 1'b0;
        chk("done_set", 64'(done), 64'd1);
        chk("busy_clear", 64'(busy), 64'd0);
        if (pulses) chk("last_addr_493_written", 64'(last_seen), 64'd1);
    endtask

    task automatic wait_fifo_drained(input string name, input int budget);
        int k;
        k = 0;
        while (rd_ptr != wr_ptr && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(wr_ptr - rd_ptr), 64'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Load A: words 0..2469, FIFO always full, start pulsed mid-load.
        begin_load();
        for (int i = 0; i < 2470; i++) push_word(11'(i));
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        run_to_done(1'b1, cyc);
        chk("done_latency_A", 64'(cyc), 64'd2964);
        chk("writes_left_A", 64'(exp_q.size()), 64'd0);
        chk_checksum("checksum_A");
`ifdef QP_LOADER_CHECKSUM_EN
        chk("checksum_A_hand", 64'(checksum), 64'd1);
`endif
        $display("[TB] load A finished after %0d cycles", cyc);

        // DONE holds and leaves extra FIFO words untouched.
        mem[wr_ptr[13:0]] = 11'h7ff;
        wr_ptr++;
        repeat (5) begin
            @(negedge clk);
            chk("done_hold", 64'(done), 64'd1);
            chk("done_no_deq", 64'(fifo_deq), 64'd0);
        end
        chk("extra_word_untouched", 64'(wr_ptr - rd_ptr), 64'd1);
        chk_checksum("checksum_stable");
        wr_ptr = rd_ptr;

        // Load B: restart from DONE, FIFO empty for 10 cycles after word 3.
        begin_load();
        for (int i = 0; i < 3; i++) push_word(11'(i * 7 + 100));
        pulse_start();
        chk("done_falls", 64'(done), 64'd0);
        wait_fifo_drained("gap_first3_drained", 20);
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            chk("gap_no_deq", 64'(fifo_deq), 64'd0);
            chk("gap_no_write", 64'(qp_mem_csb0), 64'd1);
        end
        for (int i = 3; i < 2470; i++) push_word(11'(i * 7 + 100));
        run_to_done(1'b0, cyc);
        chk("writes_left_B", 64'(exp_q.size()), 64'd0);
        chk_checksum("checksum_B");
        $display("[TB] load B finished after %0d cycles", cyc);

        // Load C: reset after 12 words.
        begin_load();
        for (int i = 0; i < 12; i++) push_word(11'(500 + i));
        pulse_start();
        wait_fifo_drained("c_12_drained", 40);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        chk("writes_left_C", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] load C reset after 12 words");

        // Load D: fresh load after reset starts at addr 0, word order restarted.
        begin_load();
        for (int i = 0; i < 2470; i++) push_word(11'(i * 5 + 3));
        pulse_start();
        run_to_done(1'b0, cyc);
        chk("done_latency_D", 64'(cyc), 64'd2964);
        chk("writes_left_D", 64'(exp_q.size()), 64'd0);
        chk_checksum("checksum_D");
        $display("[TB] load D finished after %0d cycles", cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/query_patch_loader.md
# query_patch_loader

Sits inside `top`, directly downstream of the 11-bit input FIFO that the IO pads fill through `in_fifo_wenq`/`in_fifo_wdata`. It drains the FIFO, packs each group of `PATCH_SIZE` consecutive words into one 55-bit query patch, and writes that patch into the query-patch SRAM port 0. It does this for `NUM_QUERYS` patches and then reports completion to the top-level FSM. It is the producer for the `qp_mem_*0` port, the same port the wishbone debug path reaches through `wbs_qp_mem_*0`; the muxing between the two lives outside this block.

## Interface
Parameters:
- `DATA_WIDTH`, 11: width of one FIFO word and of one patch element.
- `PATCH_SIZE`, 5: number of words per patch.
- `NUM_QUERYS`, 494 (26×19): number of patches to load.
- `ADDR_WIDTH`, 9: width of the query-memory address; must satisfy 2^`ADDR_WIDTH` ≥ `NUM_QUERYS`.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle pulse that begins a load.
- `fifo_rdata`, in, `DATA_WIDTH`: FIFO head word; show-ahead, valid whenever `fifo_rempty_n`=1.
- `fifo_rempty_n`, in, 1: FIFO holds at least one word.
- `fifo_deq`, out, 1: pops the head word at the current clock edge.
- `qp_mem_csb0`, out, 1: SRAM chip select, active-low.
- `qp_mem_web0`, out, 1: SRAM write enable, active-low.
- `qp_mem_addr0`, out, `ADDR_WIDTH`: patch address.
- `qp_mem_wpatch0`, out, `DATA_WIDTH*PATCH_SIZE`: patch write data.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: all `NUM_QUERYS` patches have been written.
- `checksum`, out, `DATA_WIDTH`: running XOR of dequeued words (see Configuration).

## Operation
- The FSM has four states: IDLE, LOAD, WRITE, DONE. Reset puts it in IDLE.
- **IDLE or DONE, `start`=1:** clear `word_cnt`, `patch_cnt` and `checksum`; drop `done`; go to LOAD.
- **LOAD:** `fifo_deq` = `fifo_rempty_n`. This is combinational from the registered state, so no bubble is inserted.
  - Each dequeued word is stored in lane `word_cnt` of the patch register, bits [`word_cnt`*11 +: 11]. Word 0 lands in the LSBs.
  - Then `word_cnt` increments.
  - On the dequeue with `word_cnt`=`PATCH_SIZE`-1: reset `word_cnt` to 0 and go to WRITE.
  - An empty FIFO stalls the state indefinitely with no timeout.
- **WRITE (exactly one cycle):**
  - `qp_mem_csb0`=0, `qp_mem_web0`=0, `qp_mem_addr0`=`patch_cnt`, `qp_mem_wpatch0`=patch register.
  - `fifo_deq`=0.
  - If `patch_cnt`=`NUM_QUERYS`-1, go to DONE; otherwise increment `patch_cnt` and go to LOAD.
- **DONE:** `done`=1 is held until the next `start`. `fifo_deq`=0, so extra FIFO words are left untouched.
- `busy` = state is LOAD or WRITE.
- `start` is ignored while `busy`=1.
- Outside WRITE: `csb0`=`web0`=1. `addr0` and `wpatch0` hold their last values, since they are driven from registers.
- `patch_cnt` never exceeds `NUM_QUERYS`-1, so the address never wraps.

## Timing
- Reset values: `fifo_deq`=0, `qp_mem_csb0`=1, `qp_mem_web0`=1, `qp_mem_addr0`=0, `qp_mem_wpatch0`=0, `busy`=0, `done`=0, `checksum`=0. State is IDLE, all counters 0.
- `start` sampled at edge N moves the FSM to LOAD at N+1. `fifo_deq` can first assert in cycle N+1.
- With the FIFO continuously non-empty, one patch takes `PATCH_SIZE`+1 = 6 cycles: 5 dequeue cycles, then 1 WRITE cycle. A full load takes 494×6 = 2964 cycles from the first LOAD cycle to entry into DONE.
- `done` rises in the cycle after the final WRITE.
- Asserting `rst_n` mid-load immediately returns every output to its reset value. A partial patch is discarded; patches already written stay in the SRAM.
- The FIFO clock/domain crossing is outside this block; every input is synchronous to `clk`.

## Configuration
- `QP_LOADER_CHECKSUM_EN` defined:
  - `checksum` is a register that XORs in every dequeued word (`checksum` ^= `fifo_rdata` on `fifo_deq`).
  - It is cleared by reset and by an accepted `start`.
  - Its final value is stable while in DONE.
- `QP_LOADER_CHECKSUM_EN` undefined: `checksum` is tied to 0 and no checksum flop is synthesized.

## Test plan
- **Full load, FIFO always full, words 0,1,2,…:**
  - Patch 0 is written at addr 0 with wpatch = {11'd4, 11'd3, 11'd2, 11'd1, 11'd0}.
  - Patch 493 is written at addr 493.
  - `done` rises 2964 cycles after the first LOAD cycle.
- **FIFO empty for 10 cycles after the 3rd word of a patch:**
  - `fifo_deq`=0 and no write occurs during the gap.
  - The patch is written intact once the remaining 2 words arrive.
- **`start` pulsed during LOAD and during WRITE:** ignored; `patch_cnt` and the sequence are unchanged.
- **`rst_n` low for 1 cycle after 12 words:**
  - All outputs return to their reset values and the state returns to IDLE.
  - A new `start` writes from addr 0 with word order restarted.
- **Restart from DONE with `start`:** `done` falls the next cycle and addr 0 is rewritten.
- **With `QP_LOADER_CHECKSUM_EN`, words 0..2469:** `checksum` equals the XOR of all 2470 words truncated to 11 bits. Without the macro it reads 0.
